// File: rtl/booth_multiplier_param.sv
// Radix-4 Booth sequential multiplier with a start/done handshake.
// Operands are extended to WIDTH+2 bits (sign- or zero-extended by
// signed_mode), so WIDTH/2+1 recoded digits cover the whole multiplier and
// the low 2*WIDTH bits of the accumulator are the exact product in both modes.
module booth_multiplier_param #(
  parameter  int WIDTH  = 64,
  localparam int N_ITER = WIDTH / 2 + 1,
  localparam int CNT_W  = $clog2(N_ITER + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 op_busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int ACC_W = 2 * WIDTH + 4;
  // Extended multiplier plus the implicit zero below bit 0 used by recoding.
  localparam int MPL_W = WIDTH + 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic                 busy_r;
  logic                 done_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [ACC_W-1:0]     acc_r;
  logic [ACC_W-1:0]     acc_next_s;
  logic [MPL_W-1:0]     mplr_r;
  logic [ACC_W-1:0]     mcand_r;
  logic [2*WIDTH-1:0]   result_r;
  logic [MPL_W-1:0]     mplr_init_s;
  logic [ACC_W-1:0]     mcand_init_s;
  logic                 sign_a_s;
  logic                 sign_b_s;
  logic                 load_s;
  logic                 step_s;
  logic                 finish_s;
  logic                 clear_s;

  // Multiple of the multiplicand selected by one overlapping 3-bit Booth group.
  function automatic logic [ACC_W-1:0] booth_multiple(input logic [2:0] bits,
                                                      input logic [ACC_W-1:0] m);
    logic [ACC_W-1:0] m2;
    logic [ACC_W-1:0] res;
    m2 = m << 1;
    case (bits)
      3'b000, 3'b111: res = {ACC_W{1'b0}};
      3'b001, 3'b010: res = m;
      3'b011:         res = m2;
      3'b100:         res = {ACC_W{1'b0}} - m2;
      3'b101, 3'b110: res = {ACC_W{1'b0}} - m;
      default:        res = {ACC_W{1'b0}};
    endcase
    return res;
  endfunction

  assign sign_a_s     = signed_mode & multiplier[WIDTH-1];
  assign sign_b_s     = signed_mode & multiplicand[WIDTH-1];
  assign mplr_init_s  = {{2{sign_a_s}}, multiplier, 1'b0};
  assign mcand_init_s = {{(WIDTH + 4){sign_b_s}}, multiplicand};
  assign acc_next_s   = acc_r + booth_multiple(mplr_r[2:0], mcand_r);

  // Next-state and datapath control decode; clear overrides everything.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    clear_s      = 1'b0;
    if (op_clear) begin
      state_next_s = ST_IDLE;
      clear_s      = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (op_start) begin
            state_next_s = ST_EXEC;
            load_s       = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_EXEC: begin
          step_s = 1'b1;
          if (cnt_r == LAST_CNT) begin
            state_next_s = ST_DONE;
            finish_s     = 1'b1;
          end else begin
            state_next_s = ST_EXEC;
          end
        end
        ST_DONE: begin
          if (op_start) begin
            state_next_s = ST_EXEC;
            load_s       = 1'b1;
          end else begin
            state_next_s = ST_DONE;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register with busy/done flags registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_EXEC);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Operand latch, Booth accumulate/shift and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {ACC_W{1'b0}};
      mplr_r   <= {MPL_W{1'b0}};
      mcand_r  <= {ACC_W{1'b0}};
      result_r <= {(2 * WIDTH){1'b0}};
    end else if (clear_s) begin
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {ACC_W{1'b0}};
      result_r <= {(2 * WIDTH){1'b0}};
    end else if (load_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      mplr_r  <= mplr_init_s;
      mcand_r <= mcand_init_s;
    end else if (step_s) begin
      acc_r   <= acc_next_s;
      mplr_r  <= mplr_r >> 2;
      mcand_r <= mcand_r << 2;
      cnt_r   <= cnt_r + CNT_ONE;
      if (finish_s) begin
        result_r <= acc_next_s[2*WIDTH-1:0];
      end
    end
  end

  assign op_busy = busy_r;
  assign op_done = done_r;
  assign result  = result_r;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Scoreboard bench for booth_multiplier_param at WIDTH=64 and WIDTH=8.
module tb_booth_multiplier_param;

  logic          clk;
  logic          reset_n;
  logic          start64, clear64, s64;
  logic [63:0]   a64, b64;
  logic          busy64, done64;
  logic [127:0]  res64;
  logic          start8, clear8, s8;
  logic [7:0]    a8, b8;
  logic          busy8, done8;
  logic [15:0]   res8;

  logic [127:0]  q64[$];
  logic [15:0]   q8[$];
  int            vectors;
  int            miscompares;

  booth_multiplier_param #(.WIDTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .op_start(start64), .op_clear(clear64),
    .signed_mode(s64), .multiplier(a64), .multiplicand(b64),
    .op_busy(busy64), .op_done(done64), .result(res64));

  booth_multiplier_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .op_start(start8), .op_clear(clear8),
    .signed_mode(s8), .multiplier(a8), .multiplicand(b8),
    .op_busy(busy8), .op_done(done8), .result(res8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int p;
    if (sm) p = int'($signed(a)) * int'($signed(b));
    else    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic sm,
                      input logic [127:0] expv, input string name);
    int edges, busy_cnt;
    logic overlap;
    logic [127:0] e;
    @(negedge clk);
    a64 = a; b64 = b; s64 = sm; start64 = 1'b1;
    q64.push_back(expv);
    @(negedge clk);
    start64 = 1'b0;
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; s64 = ~sm;
    edges = 0; busy_cnt = 0; overlap = 1'b0;
    while (!done64 && edges < 40) begin
      if (busy64) busy_cnt++;
      @(negedge clk);
      edges++;
      if (busy64 && done64) overlap = 1'b1;
    end
    e = (q64.size() > 0) ? q64.pop_front() : 128'd0;
    vectors++;
    if (res64 !== e) begin
      miscompares++;
      $display("FAIL %s result: got %h expected %h", name, res64, e);
    end
    vectors++;
    if (edges !== 33) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected 33", name, edges);
    end
    vectors++;
    if (busy_cnt !== 33) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d expected 33", name, busy_cnt);
    end
    vectors++;
    if (overlap !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_done_overlap: got 1 expected 0", name);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int edges;
    logic [15:0] e;
    @(negedge clk);
    a8 = a; b8 = b; s8 = sm; start8 = 1'b1;
    q8.push_back(ref8(a, b, sm));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    edges = 0;
    while (!done8 && edges < 12) begin
      @(negedge clk);
      edges++;
    end
    e = (q8.size() > 0) ? q8.pop_front() : 16'd0;
    vectors++;
    if (res8 !== e || edges !== 5) begin
      miscompares++;
      $display("FAIL w8 %0d*%0d sm=%0d: got %h lat %0d expected %h lat 5", a, b, sm, res8, edges, e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (res64 !== 128'd0 || busy64 !== 1'b0 || done64 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset64: got res=%h busy=%b done=%b expected 0/0/0", res64, busy64, done64);
    end
    vectors++;
    if (res8 !== 16'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset8: got res=%h busy=%b done=%b expected 0/0/0", res8, busy8, done8);
    end
  endtask

  task automatic test_products64();
    logic [63:0] ones, m100, minv;
    logic [127:0] neg12000;
    ones = ~64'd0;
    m100 = 64'd0 - 64'd100;
    minv = 64'h8000_0000_0000_0000;
    neg12000 = 128'd0 - 128'd12000;
    op64(64'd1555, 64'd131, 1'b0, 128'd203705, "u1555x131");
    op64(ones, ones, 1'b0, 128'hFFFFFFFFFFFFFFFE_0000000000000001, "u_all_ones_sq");
    op64(ones, ones, 1'b1, 128'd1, "s_m1_sq");
    op64(minv, minv, 1'b1, 128'h4000_0000_0000_0000_0000_0000_0000_0000, "s_min_sq");
    op64(m100, 64'd120, 1'b1, neg12000, "s_m100x120");
    op64(64'd120, m100, 1'b1, neg12000, "s_120xm100");
    op64(minv, ones, 1'b0, 128'h7FFFFFFFFFFFFFFF_8000000000000000, "u_min_x_ones");
  endtask

  task automatic test_abort();
    logic seen_done;
    @(negedge clk);
    a64 = 64'd7; b64 = 64'd9; s64 = 1'b0; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    repeat (9) @(negedge clk);
    clear64 = 1'b1;
    @(negedge clk);
    clear64 = 1'b0;
    vectors++;
    if (busy64 !== 1'b0 || done64 !== 1'b0 || res64 !== 128'd0) begin
      miscompares++;
      $display("FAIL abort: got busy=%b done=%b res=%h expected 0/0/0", busy64, done64, res64);
    end
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done64 || busy64) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet: got activity=1 expected 0");
    end
    a64 = 64'd3; b64 = 64'd5; start64 = 1'b1; clear64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0; clear64 = 1'b0;
    vectors++;
    if (busy64 !== 1'b0 || done64 !== 1'b0) begin
      miscompares++;
      $display("FAIL start_clear_idle: got busy=%b done=%b expected 0/0", busy64, done64);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy64 !== 1'b0 || done64 !== 1'b0 || res64 !== 128'd0) begin
      miscompares++;
      $display("FAIL start_clear_later: got busy=%b done=%b res=%h expected 0/0/0", busy64, done64, res64);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic held_bad;
    op64(64'd100, 64'd120, 1'b0, 128'd12000, "b2b_first");
    @(negedge clk);
    a64 = 64'd115; b64 = 64'd1210; s64 = 1'b0; start64 = 1'b1;
    q64.push_back(128'd139150);
    @(negedge clk);
    start64 = 1'b0;
    vectors++;
    if (busy64 !== 1'b1 || done64 !== 1'b0 || res64 !== 128'd12000) begin
      miscompares++;
      $display("FAIL b2b_restart: got busy=%b done=%b res=%h expected 1/0/12000", busy64, done64, res64);
    end
    edges = 0; held_bad = 1'b0;
    while (!done64 && edges < 40) begin
      if (res64 !== 128'd12000) held_bad = 1'b1;
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; s64 = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    vectors++;
    if (held_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_hold: got changing result expected 12000 held");
    end
    vectors++;
    if (res64 !== q64.pop_front() || edges !== 33) begin
      miscompares++;
      $display("FAIL b2b_second: got %0d lat %0d expected 139150 lat 33", res64, edges);
    end
  endtask

  task automatic test_w8_sweep();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 32; j++)
          op8(8'(i * 8 + (i % 8)), 8'(j * 8 + ((j * 3) % 8)), 1'(m));
  endtask

  task automatic test_w8_async_reset();
    op8(8'd100, 8'd100, 1'b0);
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd55; s8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (res8 !== 16'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset8: got res=%h busy=%b done=%b expected 0/0/0", res8, busy8, done8);
    end
    vectors++;
    if (res64 !== 128'd0 || busy64 !== 1'b0 || done64 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset64: got res=%h busy=%b done=%b expected 0/0/0", res64, busy64, done64);
    end
    @(negedge clk);
    reset_n = 1'b1;
    op8(8'd200, 8'd3, 1'b1);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0;
    start64 = 1'b0; clear64 = 1'b0; s64 = 1'b0; a64 = 64'd0; b64 = 64'd0;
    start8 = 1'b0; clear8 = 1'b0; s8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_products64();
    test_abort();
    test_back_to_back();
    test_w8_sweep();
    test_w8_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
